// File: rtl/sr_trace_buf_pkg.sv
// Shared definitions for the decode-stage trace buffer: flag bit positions,
// entry field layout and the entry width helper.
package sr_trace_buf_pkg;

    // Flag bit positions within rd_flags
    localparam int unsigned SR_TRACE_F_VLD    = 0;
    localparam int unsigned SR_TRACE_F_MISS   = 1;
    localparam int unsigned SR_TRACE_F_BUBBLE = 2;
    localparam int unsigned SR_TRACE_NFLAGS   = 3;

    // Entry layout, LSB first: pc, instr, flags, cycle
    localparam int unsigned SR_TRACE_PC_LSB    = 0;
    localparam int unsigned SR_TRACE_INSTR_LSB = 32;
    localparam int unsigned SR_TRACE_FLAGS_LSB = 64;
    localparam int unsigned SR_TRACE_CYCLE_LSB = 64 + SR_TRACE_NFLAGS;

    // Field order matches the bit positions above (vld in bit 0)
    typedef struct packed {
        logic bubble;
        logic miss;
        logic vld;
    } sr_trace_flags_t;

    // Stored entry width for a given timestamp width
    function automatic int unsigned sr_trace_entry_w(input int unsigned cw);
        return 64 + SR_TRACE_NFLAGS + cw;
    endfunction

endpackage

// File: rtl/sr_trace_fifo.sv
// Generic synchronous FIFO. Read data comes straight from the storage array at
// the read pointer, so the head is visible the cycle after it is written.
// Full and empty are told apart by the occupancy counter; pointers wrap
// naturally because DEPTH is a power of two.
module sr_trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Clear wins over both ports; a push into a full FIFO is allowed only
    // when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
    assign w_do_push = i_push & ~i_clear & (~o_full | w_do_pop);

    // Pointer and occupancy update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage; reset to zero so the head reads zero out of reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/sr_trace_buf.sv
// Decode-stage trace buffer. Qualifies events from the pipeline debug nets,
// stamps them with a free-running cycle counter and queues them for a
// valid/ready consumer. Overflow is sticky until clear or reset.
// Build option: define SR_TRACE_FILTER_EN to skip bubble-only slots.
module sr_trace_buf
    import sr_trace_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_trace_en,
    input  logic                     i_clear,
    input  logic [31:0]              i_pc,
    input  logic [31:0]              i_instr,
    input  logic                     i_vld,
    input  logic                     i_pc_src,
    input  logic                     i_bubble,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [31:0]              o_rd_pc,
    output logic [31:0]              o_rd_instr,
    output logic [2:0]               o_rd_flags,
    output logic [CW-1:0]            o_rd_cycle,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int unsigned EW = sr_trace_entry_w(CW);

    logic [CW-1:0]   r_ts;
    logic            r_overflow;
    logic            w_event;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;
    sr_trace_flags_t w_flags;
    logic [EW-1:0]   w_wdata;
    logic [EW-1:0]   w_rdata;

`ifdef SR_TRACE_FILTER_EN
    // Bubble-only slots are not logged, leaving instruction slots and misses
    assign w_event = i_trace_en & i_vld;
`else
    assign w_event = i_trace_en & (i_vld | i_bubble | (i_pc_src & i_vld));
`endif

    assign w_flags.bubble = i_bubble;
    assign w_flags.miss   = i_pc_src & i_vld;
    assign w_flags.vld    = i_vld;

    assign w_wdata = {r_ts, w_flags, i_instr, i_pc};

    assign w_pop  = ~w_empty & i_rd_ready;
    assign w_drop = w_event & w_full & ~w_pop & ~i_clear;

    sr_trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_push  (w_event),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Free-running timestamp; clear deliberately leaves it running
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Sticky overflow: set on a dropped event, cleared only by clear/reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_rd_valid = ~w_empty;
    assign o_overflow = r_overflow;
    assign o_rd_pc    = w_rdata[SR_TRACE_PC_LSB +: 32];
    assign o_rd_instr = w_rdata[SR_TRACE_INSTR_LSB +: 32];
    assign o_rd_flags = w_rdata[SR_TRACE_FLAGS_LSB +: SR_TRACE_NFLAGS];
    assign o_rd_cycle = w_rdata[SR_TRACE_CYCLE_LSB +: CW];

endmodule

// File: tb/tb_sr_trace_buf.sv
// Self-checking bench for sr_trace_buf: a queue-based model of the trace
// FIFO, directed scenarios with literal expectations, then random traffic.
module tb_sr_trace_buf;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 32;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [2:0]    flags;
        logic [CW-1:0] cyc;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trace_en;
    logic          clear;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          vld;
    logic          pc_src;
    logic          bubble;
    logic          rd_valid;
    logic          rd_ready;
    logic [31:0]   rd_pc;
    logic [31:0]   rd_instr;
    logic [2:0]    rd_flags;
    logic [CW-1:0] rd_cycle;
    logic [4:0]    count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    ent_t          q[$];
    bit            m_ovf;
    logic [CW-1:0] m_ts;

    always #5 clk = ~clk;

    sr_trace_buf #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_trace_en (trace_en),
        .i_clear    (clear),
        .i_pc       (pc),
        .i_instr    (instr),
        .i_vld      (vld),
        .i_pc_src   (pc_src),
        .i_bubble   (bubble),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_rd_pc    (rd_pc),
        .o_rd_instr (rd_instr),
        .o_rd_flags (rd_flags),
        .o_rd_cycle (rd_cycle),
        .o_count    (count),
        .o_overflow (overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_ovf = 1'b0;
        m_ts  = '0;
    endtask

    // Compare the DUT against the model state (called away from the edge)
    task automatic compare_model();
        chk("rd_valid", {63'd0, rd_valid}, {63'd0, q.size() != 0});
        chk("count", {59'd0, count}, 64'(q.size()));
        chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        if (q.size() != 0) begin
            chk("rd_pc", {32'd0, rd_pc}, {32'd0, q[0].pc});
            chk("rd_instr", {32'd0, rd_instr}, {32'd0, q[0].instr});
            chk("rd_flags", {61'd0, rd_flags}, {61'd0, q[0].flags});
            chk("rd_cycle", {32'd0, rd_cycle}, {32'd0, q[0].cyc});
        end
    endtask

    // One clock: check, drive, advance the model, wait for the next negedge
    task automatic step(input bit en, input bit clr, input bit v, input bit ps, input bit bub,
                        input bit rdy, input logic [31:0] p, input logic [31:0] ins);
        bit   ev;
        bit   pop;
        bit   full;
        ent_t e;
        compare_model();
        trace_en = en;
        clear    = clr;
        vld      = v;
        pc_src   = ps;
        bubble   = bub;
        rd_ready = rdy;
        pc       = p;
        instr    = ins;
        ev = en & (v | bub);
`ifdef SR_TRACE_FILTER_EN
        if (bub && !v) ev = 1'b0;
`endif
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = (q.size() != 0) && rdy;
            full = (q.size() == DEPTH);
            if (pop) void'(q.pop_front());
            if (ev) begin
                if (!full || pop) begin
                    e.pc    = p;
                    e.instr = ins;
                    e.flags = {bub, ps & v, v};
                    e.cyc   = m_ts;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_ts = m_ts + 1'b1;
        @(negedge clk);
    endtask

    task automatic ev_step(input logic [31:0] p, input bit rdy);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rdy, p, $urandom);
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rdy, 32'd0, 32'd0);
    endtask

    initial begin
        int pct;
        rst_n = 1'b0;
        trace_en = 1'b0; clear = 1'b0; vld = 1'b0; pc_src = 1'b0; bubble = 1'b0;
        rd_ready = 1'b0; pc = '0; instr = '0;
        m_reset();
        #12;
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_count", {59'd0, count}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_rd_pc", {32'd0, rd_pc}, 64'd0);
        chk("rst_rd_instr", {32'd0, rd_instr}, 64'd0);
        chk("rst_rd_flags", {61'd0, rd_flags}, 64'd0);
        chk("rst_rd_cycle", {32'd0, rd_cycle}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three consecutive instructions, then drain
        ev_step(32'h00, 1'b0);
        ev_step(32'h04, 1'b0);
        ev_step(32'h08, 1'b0);
        chk("t1_count", {59'd0, count}, 64'd3);
        chk("t1_pc0", {32'd0, rd_pc}, 64'h00);
        chk("t1_flags0", {61'd0, rd_flags}, 64'b001);
        chk("t1_cyc0", {32'd0, rd_cycle}, 64'd0);
        idle(1'b1);
        chk("t1_pc1", {32'd0, rd_pc}, 64'h04);
        chk("t1_cyc1", {32'd0, rd_cycle}, 64'd1);
        idle(1'b1);
        chk("t1_pc2", {32'd0, rd_pc}, 64'h08);
        chk("t1_cyc2", {32'd0, rd_cycle}, 64'd2);
        idle(1'b1);
        chk("t1_empty", {63'd0, rd_valid}, 64'd0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) ev_step(32'h100 + 32'(4 * i), 1'b0);
        chk("t2_full_count", {59'd0, count}, 64'd16);
        chk("t2_no_ovf_yet", {63'd0, overflow}, 64'd0);
        ev_step(32'h200, 1'b0);
        chk("t2_count_held", {59'd0, count}, 64'd16);
        chk("t2_ovf", {63'd0, overflow}, 64'd1);
        idle(1'b1);
        chk("t2_head_after_pop", {32'd0, rd_pc}, 64'h104);
        for (int i = 0; i < 15; i++) idle(1'b1);
        chk("t2_drained", {59'd0, count}, 64'd0);
        chk("t2_ovf_sticky", {63'd0, overflow}, 64'd1);

        // Push and pop together while full
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t3_ovf_cleared", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 16; i++) ev_step(32'h300 + 32'(4 * i), 1'b0);
        ev_step(32'hABC, 1'b1);
        chk("t3_count", {59'd0, count}, 64'd16);
        chk("t3_ovf", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 15; i++) idle(1'b1);
        chk("t3_last_pc", {32'd0, rd_pc}, 64'hABC);
        idle(1'b1);

        // Flag encodings and trace_en gating
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h13);
        chk("t4_miss_flags", {61'd0, rd_flags}, 64'b011);
        chk("t4_miss_pc", {32'd0, rd_pc}, 64'h10);
        idle(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
`ifdef SR_TRACE_FILTER_EN
        chk("t4_bubble_filtered", {59'd0, count}, 64'd0);
`else
        chk("t4_bubble_count", {59'd0, count}, 64'd1);
        chk("t4_bubble_flags", {61'd0, rd_flags}, 64'b100);
`endif
        idle(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h18, 32'h1);
        chk("t4_trace_off", {59'd0, count}, 64'd0);

        // Clear with pending entries and a same-cycle event
        for (int i = 0; i < 5; i++) ev_step(32'h400 + 32'(4 * i), 1'b0);
        chk("t5_count5", {59'd0, count}, 64'd5);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 32'h2);
        chk("t5_count", {59'd0, count}, 64'd0);
        chk("t5_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("t5_ovf", {63'd0, overflow}, 64'd0);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 8; i++) ev_step(32'h600 + 32'(4 * i), 1'b0);
        idle(1'b1);
        chk("t6_count7", {59'd0, count}, 64'd7);
        trace_en = 1'b0; vld = 1'b0; bubble = 1'b0; rd_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("t6_count", {59'd0, count}, 64'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ev_step(32'h40, 1'b0);
        chk("t6_ts_restart", {32'd0, rd_cycle}, 64'd0);
        chk("t6_pc", {32'd0, rd_pc}, 64'h40);
        idle(1'b1);

        // Random traffic with varying consumer back-pressure
        for (int ph = 0; ph < 15; ph++) begin
            case (ph % 3)
                0:       pct = 10;
                1:       pct = 50;
                default: pct = 90;
            endcase
            for (int i = 0; i < 200; i++) begin
                step(($urandom % 8) != 0, ($urandom % 64) == 0, $urandom % 2, $urandom % 2,
                     $urandom % 2, ($urandom % 100) < pct, $urandom, $urandom);
            end
        end
        compare_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
